// File: rtl/y86_mem_pkg.sv
// Shared types and constants for the Y86 data-memory responder.
// DMEM_SINGLE_CYCLE_EN widens the RAM port to a full word (single-cycle access).
package y86_mem_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} state_e;

    localparam int WORD_BYTES = 8;
    localparam int BEAT_W     = 3;

`ifdef DMEM_SINGLE_CYCLE_EN
    localparam int RAM_PORT_W = 64;
`else
    localparam int RAM_PORT_W = 8;
`endif

    // MSB of the word lane carried on beat k; big-endian, so beat 0 is [63:56]
    function automatic logic [5:0] lane_msb(input logic [BEAT_W-1:0] beat);
        return 6'd63 - {beat, 3'b000};
    endfunction

endpackage

// File: rtl/y86_byte_ram.sv
// Byte array with synchronous write and combinational read; the port is one
// byte wide, or a full big-endian word when DMEM_SINGLE_CYCLE_EN is defined.
module y86_byte_ram
    import y86_mem_pkg::*;
#(
    parameter int MEM_BYTES = 256,
    parameter int AW        = $clog2(MEM_BYTES)
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [AW-1:0]         addr_i,
    input  logic [RAM_PORT_W-1:0] wdata_i,
    output logic [RAM_PORT_W-1:0] rdata_o
);

    localparam int LANES = RAM_PORT_W / 8;

    logic [7:0] mem_q [MEM_BYTES];

    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int k = 0; k < LANES; k++) begin
                mem_q[addr_i + AW'(k)] <= wdata_i[RAM_PORT_W-1-8*k -: 8];
            end
        end
    end

    always_comb begin
        rdata_o = '0;
        for (int k = 0; k < LANES; k++) begin
            rdata_o[RAM_PORT_W-1-8*k -: 8] = mem_q[addr_i + AW'(k)];
        end
    end

endmodule

// File: rtl/y86_dmem_responder.sv
// Valid/ready memory-side responder for Y86 64-bit big-endian loads/stores.
// DMEM_SINGLE_CYCLE_EN selects a one-cycle word access instead of 8 byte beats.
module y86_dmem_responder
    import y86_mem_pkg::*;
#(
    parameter int MEM_BYTES = 256,
    parameter int ADDR_W    = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [63:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [63:0]       rsp_rdata,
    output logic              rsp_error
);

    localparam int AW = $clog2(MEM_BYTES);
    localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(MEM_BYTES - WORD_BYTES);

    state_e state_q, state_d;
    logic              write_q, error_q, rsp_valid_q;
    logic [AW-1:0]     addr_q;
    logic [63:0]       wdata_q, rdata_q;
`ifndef DMEM_SINGLE_CYCLE_EN
    logic [BEAT_W-1:0] beat_q;
`endif

    logic                  ram_we;
    logic [AW-1:0]         ram_addr;
    logic [RAM_PORT_W-1:0] ram_wdata, ram_rdata;

    // Full-width compare so addresses near 2^ADDR_W never alias into range
    wire addr_bad = req_addr > MAX_ADDR;
    wire req_fire = req_valid && (state_q == ST_IDLE);
    wire rsp_fire = rsp_valid_q && rsp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (req_fire) state_d = addr_bad ? ST_RESP : ST_ACCESS;
`ifdef DMEM_SINGLE_CYCLE_EN
            ST_ACCESS: state_d = ST_RESP;
`else
            ST_ACCESS: if (beat_q == BEAT_W'(WORD_BYTES - 1)) state_d = ST_RESP;
`endif
            ST_RESP:   if (rsp_fire) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state_q == ST_IDLE);
        ram_we    = (state_q == ST_ACCESS) && write_q;
`ifdef DMEM_SINGLE_CYCLE_EN
        ram_addr  = addr_q;
        ram_wdata = wdata_q;
`else
        ram_addr  = addr_q + AW'(beat_q);
        ram_wdata = wdata_q[lane_msb(beat_q) -: 8];
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            error_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
`ifndef DMEM_SINGLE_CYCLE_EN
            beat_q      <= '0;
`endif
        end else begin
            if (req_fire) begin
                write_q <= req_write;
                addr_q  <= req_addr[AW-1:0];
                wdata_q <= req_wdata;
                rdata_q <= '0;
                error_q <= addr_bad;
`ifndef DMEM_SINGLE_CYCLE_EN
                beat_q  <= '0;
`endif
            end else if (state_q == ST_ACCESS) begin
`ifdef DMEM_SINGLE_CYCLE_EN
                if (!write_q) rdata_q <= ram_rdata;
`else
                beat_q <= beat_q + BEAT_W'(1);
                if (!write_q) rdata_q[lane_msb(beat_q) -: 8] <= ram_rdata;
`endif
            end
            // Valid rises one cycle into RESP, then holds until the handshake
            rsp_valid_q <= (state_q == ST_RESP) && !rsp_fire;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign rsp_error = error_q;

    y86_byte_ram #(
        .MEM_BYTES (MEM_BYTES),
        .AW        (AW)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

endmodule
